// File: rtl/ysyx_22041461_wbu.sv
// ysyx_22041461_wbu -- write-back unit.
//
// Collects results from the EXU and LSU, arbitrates them onto the single
// register-file write port (LSU has fixed priority) and keeps a 32-entry
// busy scoreboard so decode can stall on read-after-write hazards.
//
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   iss_valid, iss_rd        decode issue of a register writer (sets busy)
//   rs1, rs2                 source indices read by decode
//   rs1_busy, rs2_busy       source has a pending write
//   rs1_byp, rs2_byp         bypass data (bypass build only, else 0)
//   exu_valid/ready/sel/rd   EXU result handshake, select and destination
//   exu_dest/pc/snpc/imm     EXU candidate write values
//   lsu_valid/ready/rd/mem   LSU load result handshake, destination, data
//   wb_wen, wb_rd, wb_data   registered register-file write port
//
// Optional feature: define YSYX_22041461_WB_BYPASS_EN to forward the value
// being written back this cycle to a matching source and suppress its busy.

module ysyx_22041461_wbu (
    input  logic        clk,
    input  logic        rst,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic [63:0] rs1_byp,
    output logic [63:0] rs2_byp,
    input  logic        exu_valid,
    output logic        exu_ready,
    input  logic [2:0]  exu_sel,
    input  logic [4:0]  exu_rd,
    input  logic [63:0] exu_dest,
    input  logic [63:0] exu_pc,
    input  logic [63:0] exu_snpc,
    input  logic [63:0] exu_imm,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_rd,
    input  logic [63:0] lsu_mem,
    output logic        wb_wen,
    output logic [4:0]  wb_rd,
    output logic [63:0] wb_data
);

    logic        wb_wen_q,  wb_wen_d;
    logic [4:0]  wb_rd_q,   wb_rd_d;
    logic [63:0] wb_data_q, wb_data_d;
    logic [31:0] busy_q,    busy_d;

    logic [63:0] exu_val;
    logic        exu_wr;

    // LSU always wins; EXU only proceeds when no load is presented.
    assign lsu_ready = 1'b1;
    assign exu_ready = ~lsu_valid;

    always_comb begin
        exu_val = 64'd0;
        exu_wr  = 1'b0;
        case (exu_sel)
            3'b001: begin exu_val = exu_dest; exu_wr = 1'b1; end
            3'b010: begin exu_val = exu_pc;   exu_wr = 1'b1; end
            3'b011: begin exu_val = exu_snpc; exu_wr = 1'b1; end
            3'b100: begin exu_val = exu_imm;  exu_wr = 1'b1; end
            default: begin exu_val = 64'd0;   exu_wr = 1'b0; end
        endcase
    end

    always_comb begin
        wb_wen_d  = 1'b0;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        if (lsu_valid) begin
            wb_wen_d  = (lsu_rd != 5'd0);
            wb_rd_d   = lsu_rd;
            wb_data_d = lsu_mem;
        end else if (exu_valid) begin
            // No-write selects and rd 0 are consumed without a write.
            wb_wen_d  = exu_wr && (exu_rd != 5'd0);
            wb_rd_d   = exu_rd;
            wb_data_d = exu_val;
        end
    end

    always_comb begin
        busy_d = busy_q;
        if (wb_wen_q) begin
            busy_d[wb_rd_q] = 1'b0;
        end
        // Applied after the clear: a newer producer in flight must stay busy.
        if (iss_valid) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_wen_q  <= 1'b0;
            wb_rd_q   <= 5'd0;
            wb_data_q <= 64'd0;
            busy_q    <= 32'd0;
        end else begin
            wb_wen_q  <= wb_wen_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            busy_q    <= busy_d;
        end
    end

    assign wb_wen  = wb_wen_q;
    assign wb_rd   = wb_rd_q;
    assign wb_data = wb_data_q;

`ifdef YSYX_22041461_WB_BYPASS_EN
    logic hit1, hit2;

    assign hit1     = wb_wen_q && (wb_rd_q == rs1) && (rs1 != 5'd0);
    assign hit2     = wb_wen_q && (wb_rd_q == rs2) && (rs2 != 5'd0);
    assign rs1_busy = busy_q[rs1] & ~hit1;
    assign rs2_busy = busy_q[rs2] & ~hit2;
    assign rs1_byp  = hit1 ? wb_data_q : 64'd0;
    assign rs2_byp  = hit2 ? wb_data_q : 64'd0;
`else
    assign rs1_busy = busy_q[rs1];
    assign rs2_busy = busy_q[rs2];
    assign rs1_byp  = 64'd0;
    assign rs2_byp  = 64'd0;
`endif

endmodule

// File: tb/tb_ysyx_22041461_wbu.sv
module tb_ysyx_22041461_wbu;

`ifdef YSYX_22041461_WB_BYPASS_EN
    localparam bit Byp = 1'b1;
`else
    localparam bit Byp = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  rs1, rs2;
    logic        rs1_busy, rs2_busy;
    logic [63:0] rs1_byp, rs2_byp;
    logic        exu_valid, exu_ready;
    logic [2:0]  exu_sel;
    logic [4:0]  exu_rd;
    logic [63:0] exu_dest, exu_pc, exu_snpc, exu_imm;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [63:0] lsu_mem;
    logic        wb_wen;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;

    int errors = 0;
    int checks = 0;

    // Reference model state: what the write port and scoreboard should hold.
    bit          m_wen;
    bit [4:0]    m_rd;
    bit [63:0]   m_data;
    bit          m_data_known;
    bit          m_busy [32];

    always #5 clk = ~clk;

    ysyx_22041461_wbu dut (
        .clk       (clk),
        .rst       (rst),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .rs1_busy  (rs1_busy),
        .rs2_busy  (rs2_busy),
        .rs1_byp   (rs1_byp),
        .rs2_byp   (rs2_byp),
        .exu_valid (exu_valid),
        .exu_ready (exu_ready),
        .exu_sel   (exu_sel),
        .exu_rd    (exu_rd),
        .exu_dest  (exu_dest),
        .exu_pc    (exu_pc),
        .exu_snpc  (exu_snpc),
        .exu_imm   (exu_imm),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_mem   (lsu_mem),
        .wb_wen    (wb_wen),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data)
    );

    // Apply the specification's per-edge rules to the model using the inputs
    // presented at this edge.
    task automatic model_edge();
        bit [63:0] val;
        bit        wr;
        if (!rst) begin
            m_wen = 0; m_rd = 0; m_data = 0; m_data_known = 1;
            for (int i = 0; i < 32; i++) m_busy[i] = 0;
            return;
        end
        if (m_wen) m_busy[m_rd] = 0;
        if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1;
        if (lsu_valid) begin
            m_wen = (lsu_rd != 0); m_rd = lsu_rd; m_data = lsu_mem; m_data_known = 1;
        end else if (exu_valid) begin
            wr = 1;
            val = 0;
            if (exu_sel == 3'd1)      val = exu_dest;
            else if (exu_sel == 3'd2) val = exu_pc;
            else if (exu_sel == 3'd3) val = exu_snpc;
            else if (exu_sel == 3'd4) val = exu_imm;
            else                      wr = 0;
            m_wen = wr && (exu_rd != 0);
            m_rd = exu_rd;
            m_data = val;
            m_data_known = wr;
        end else begin
            m_wen = 0;
        end
    endtask

    function automatic bit exp_busy(input bit [4:0] rs);
        if (rs == 0) return 0;
        if (Byp && m_wen && m_rd == rs) return 0;
        return m_busy[rs];
    endfunction

    function automatic bit [63:0] exp_byp(input bit [4:0] rs);
        if (Byp && m_wen && m_rd == rs && rs != 0) return m_data;
        return 64'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        iss_valid = 0; iss_rd = 0; exu_valid = 0; exu_sel = 0; exu_rd = 0;
        lsu_valid = 0; lsu_rd = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        idle();
        rs1 = 5; rs2 = 0;
        lsu_valid = 1; lsu_rd = 5; lsu_mem = 64'h1234;
        iss_valid = 1; iss_rd = 5;
        exu_dest = 0; exu_pc = 0; exu_snpc = 0; exu_imm = 0;
        tick();
        checks++;
        if (exu_ready !== 1'b0 || lsu_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_handshake: exu_ready=%b lsu_ready=%b want 0 1",
                     exu_ready, lsu_ready);
        end
        tick();
        rst = 1;
        idle();
        #1;
        checks++;
        if (wb_wen !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 64'd0) begin
            errors++;
            $display("FAIL reset_wb: wen=%b rd=%0d data=%h want 0 0 0", wb_wen, wb_rd, wb_data);
        end
        checks++;
        if (rs1_busy !== 1'b0 || rs1_byp !== 64'd0 || rs2_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: rs1_busy=%b rs1_byp=%h rs2_busy=%b want 0 0 0",
                     rs1_busy, rs1_byp, rs2_busy);
        end
        tick();
    endtask

    task automatic test_exu_write();
        iss_valid = 1; iss_rd = 3; rs1 = 3;
        tick();
        iss_valid = 0;
        exu_valid = 1; exu_sel = 3'b011; exu_rd = 3; exu_snpc = 64'h80000008;
        #1;
        checks++;
        if (rs1_busy !== 1'b1 || exu_ready !== 1'b1) begin
            errors++;
            $display("FAIL exu_cycle_n: rs1_busy=%b exu_ready=%b want 1 1", rs1_busy, exu_ready);
        end
        tick();
        exu_valid = 0;
        #1;
        checks++;
        if (wb_wen !== 1'b1 || wb_rd !== 5'd3 || wb_data !== 64'h80000008) begin
            errors++;
            $display("FAIL exu_wb: wen=%b rd=%0d data=%h want 1 3 80000008", wb_wen, wb_rd, wb_data);
        end
        checks++;
        if (rs1_busy !== !Byp || rs1_byp !== (Byp ? 64'h80000008 : 64'd0)) begin
            errors++;
            $display("FAIL exu_n1_busy: rs1_busy=%b rs1_byp=%h want %b", rs1_busy, rs1_byp, !Byp);
        end
        tick();
        checks++;
        if (wb_wen !== 1'b0 || rs1_busy !== 1'b0 || wb_data !== 64'h80000008) begin
            errors++;
            $display("FAIL exu_n2: wen=%b rs1_busy=%b data=%h want 0 0 80000008",
                     wb_wen, rs1_busy, wb_data);
        end
    endtask

    task automatic test_contention();
        exu_valid = 1; exu_sel = 3'b001; exu_rd = 8; exu_dest = 64'h5555;
        lsu_valid = 1; lsu_rd = 7; lsu_mem = 64'hdeadbeef;
        #1;
        checks++;
        if (exu_ready !== 1'b0) begin
            errors++;
            $display("FAIL cont_ready: exu_ready=%b want 0", exu_ready);
        end
        tick();
        lsu_valid = 0;
        #1;
        checks++;
        if (wb_wen !== 1'b1 || wb_rd !== 5'd7 || wb_data !== 64'hdeadbeef || exu_ready !== 1'b1) begin
            errors++;
            $display("FAIL cont_lsu: wen=%b rd=%0d data=%h ready=%b want 1 7 deadbeef 1",
                     wb_wen, wb_rd, wb_data, exu_ready);
        end
        tick();
        exu_valid = 0;
        #1;
        checks++;
        if (wb_wen !== 1'b1 || wb_rd !== 5'd8 || wb_data !== 64'h5555) begin
            errors++;
            $display("FAIL cont_exu: wen=%b rd=%0d data=%h want 1 8 5555", wb_wen, wb_rd, wb_data);
        end
        tick();
    endtask

    task automatic test_x0_nowrite();
        iss_valid = 1; iss_rd = 4; rs1 = 4;
        tick();
        iss_valid = 0;
        exu_valid = 1; exu_sel = 3'b001; exu_rd = 0; exu_dest = 64'h77;
        tick();
        exu_sel = 3'b000; exu_rd = 4;
        #1;
        checks++;
        if (wb_wen !== 1'b0 || wb_rd !== 5'd0 || exu_ready !== 1'b1) begin
            errors++;
            $display("FAIL x0_write: wen=%b rd=%0d ready=%b want 0 0 1", wb_wen, wb_rd, exu_ready);
        end
        tick();
        exu_valid = 0;
        #1;
        checks++;
        if (wb_wen !== 1'b0 || wb_rd !== 5'd4 || rs1_busy !== 1'b1) begin
            errors++;
            $display("FAIL nowrite_sel: wen=%b rd=%0d rs1_busy=%b want 0 4 1",
                     wb_wen, wb_rd, rs1_busy);
        end
        lsu_valid = 1; lsu_rd = 4; lsu_mem = 64'h44;
        tick();
        lsu_valid = 0;
        tick();
    endtask

    task automatic test_collision();
        iss_valid = 1; iss_rd = 9; rs2 = 9;
        tick();
        iss_valid = 0;
        exu_valid = 1; exu_sel = 3'b100; exu_rd = 9; exu_imm = 64'h0abc_0000_0099;
        tick();
        exu_valid = 0;
        iss_valid = 1; iss_rd = 9;
        #1;
        checks++;
        if (wb_wen !== 1'b1 || rs2_busy !== !Byp
            || rs2_byp !== (Byp ? 64'h0abc_0000_0099 : 64'd0)) begin
            errors++;
            $display("FAIL bypass_rs2: wen=%b rs2_busy=%b rs2_byp=%h want busy %b",
                     wb_wen, rs2_busy, rs2_byp, !Byp);
        end
        tick();
        iss_valid = 0;
        #1;
        checks++;
        if (rs2_busy !== 1'b1 || wb_wen !== 1'b0) begin
            errors++;
            $display("FAIL collide_set_wins: rs2_busy=%b wen=%b want 1 0", rs2_busy, wb_wen);
        end
        lsu_valid = 1; lsu_rd = 9; lsu_mem = 64'h99;
        tick();
        lsu_valid = 0;
        tick();
        checks++;
        if (rs2_busy !== 1'b0) begin
            errors++;
            $display("FAIL collide_clear: rs2_busy=%b want 0", rs2_busy);
        end
    endtask

    task automatic test_random();
        bit [4:0] pick [8];
        pick[0] = 0; pick[1] = 1; pick[2] = 2; pick[3] = 3;
        pick[4] = 9; pick[5] = 17; pick[6] = 30; pick[7] = 31;
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 49) != 0);
            iss_valid = ($urandom_range(0, 2) == 0);
            iss_rd    = pick[$urandom_range(0, 7)];
            rs1       = pick[$urandom_range(0, 7)];
            rs2       = pick[$urandom_range(0, 7)];
            exu_valid = ($urandom_range(0, 1) == 1);
            exu_sel   = 3'($urandom_range(0, 7));
            exu_rd    = pick[$urandom_range(0, 7)];
            exu_dest  = {$urandom, $urandom};
            exu_pc    = {$urandom, $urandom};
            exu_snpc  = {$urandom, $urandom};
            exu_imm   = {$urandom, $urandom};
            lsu_valid = ($urandom_range(0, 3) == 0);
            lsu_rd    = pick[$urandom_range(0, 7)];
            lsu_mem   = {$urandom, $urandom};
            #2;
            checks++;
            if (exu_ready !== !lsu_valid || lsu_ready !== 1'b1) begin
                errors++;
                $display("FAIL rnd_ready c=%0d: exu_ready=%b lsu_ready=%b want %b 1",
                         c, exu_ready, lsu_ready, !lsu_valid);
            end
            checks++;
            if (wb_wen !== m_wen || (m_wen && wb_rd !== m_rd)) begin
                errors++;
                $display("FAIL rnd_wb c=%0d: wen=%b rd=%0d want %b %0d", c, wb_wen, wb_rd, m_wen, m_rd);
            end
            if (m_data_known) begin
                checks++;
                if (wb_data !== m_data || wb_rd !== m_rd) begin
                    errors++;
                    $display("FAIL rnd_data c=%0d: rd=%0d data=%h want %0d %h",
                             c, wb_rd, wb_data, m_rd, m_data);
                end
            end
            checks++;
            if (rs1_busy !== exp_busy(rs1) || rs2_busy !== exp_busy(rs2)) begin
                errors++;
                $display("FAIL rnd_busy c=%0d rs1=%0d rs2=%0d: busy=%b%b want %b%b", c, rs1, rs2,
                         rs1_busy, rs2_busy, exp_busy(rs1), exp_busy(rs2));
            end
            checks++;
            if (rs1_byp !== exp_byp(rs1) || rs2_byp !== exp_byp(rs2)) begin
                errors++;
                $display("FAIL rnd_byp c=%0d: byp1=%h byp2=%h want %h %h",
                         c, rs1_byp, rs2_byp, exp_byp(rs1), exp_byp(rs2));
            end
            tick();
        end
        rst = 1;
        idle();
    endtask

    initial begin
        test_reset();
        test_exu_write();
        test_contention();
        test_x0_nowrite();
        test_collision();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_22041461_wbu.md
# ysyx_22041461_wbu

Write-back unit for the ysyx_22041461 core. It collects results from the execute unit (EXU) and the load/store unit (LSU), arbitrates them onto the single register-file write port, and tracks pending destination registers in a 32-bit scoreboard so decode can stall on read-after-write hazards. It sits between EXU/LSU and the general-purpose register file; the register file's rs1/rs2 indices are also fed here for hazard checks.

## Interface
- No parameters. XLEN is fixed at 64 and there are 32 registers.
- clk  in  1  core clock; all state updates on the posedge.
- rst  in  1  synchronous reset, active-low.
- iss_valid  in  1  decode issues an instruction this cycle that will write a register.
- iss_rd  in  5  destination of the issued instruction; sets its scoreboard bit.
- rs1, rs2  in  5  source indices being read by decode.
- rs1_busy, rs2_busy  out  1  source has a pending write; decode must stall.
- rs1_byp, rs2_byp  out  64  bypass data; meaningful only with the bypass build.
- exu_valid  in  1  EXU result present.
- exu_ready  out  1  EXU result accepted this cycle.
- exu_sel  in  3  source select: 001 dest, 010 pc, 011 snpc, 100 imm, others mean no write.
- exu_rd  in  5  EXU destination.
- exu_dest, exu_pc, exu_snpc, exu_imm  in  64  EXU candidate values.
- lsu_valid  in  1  load result present.
- lsu_ready  out  1  load accepted; tied to 1.
- lsu_rd  in  5  load destination.
- lsu_mem  in  64  load data, already extended by the LSU.
- wb_wen  out  1  register-file write enable.
- wb_rd  out  5  register-file write index.
- wb_data  out  64  register-file write data.

## Operation
- Arbitration: LSU has fixed priority. exu_ready = !lsu_valid, and lsu_ready is always 1. A handshake completes when valid and ready are both high in the same cycle.
- Accepted result: on the next posedge, the output register loads wb_rd = rd and wb_data = the selected value.
  - wb_wen = 1 only when rd != 0 and the select is a write code. LSU always counts as a write.
  - An EXU accept with a no-write select, or any accept to rd = 0, leaves wb_wen = 0 but is still consumed.
- No accept in a cycle: wb_wen = 0 on the next edge. wb_rd and wb_data hold their values.
- Scoreboard: 32 busy bits; bit 0 is hardwired to 0.
  - Set: iss_valid with iss_rd != 0 sets busy[iss_rd].
  - Clear: wb_wen clears busy[wb_rd] at the edge ending the write cycle.
  - Set and clear of the same index in the same cycle: the set wins, because a newer producer is in flight.
- Hazard outputs: rsN_busy = busy[rsN]. They are combinational from the registered busy bits, and always 0 for index 0.
- There is a single outstanding producer per rd. Issuing a second writer to a busy rd is a decode error; the scoreboard stays set until the next writeback to that rd.

## Timing
- Reset (rst = 0 at a posedge) clears everything: wb_wen = 0, wb_rd = 0, wb_data = 0, all busy bits = 0. Resulting outputs: rs1_busy = rs2_busy = 0, rs1_byp = rs2_byp = 0.
- Reset mid-operation discards any result accepted in that same cycle. The handshake outputs (exu_ready, lsu_ready) stay combinational during reset.
- Latency: result accepted in cycle N gives wb_wen = 1 during cycle N+1, and the register file commits at the end of N+1.
- Busy clears at the end of N+1, so rsN_busy = 0 from cycle N+2.
- Throughput: one writeback per cycle. When both producers are valid, EXU stalls one cycle per LSU beat.

## Configuration
- Macro: YSYX_22041461_WB_BYPASS_EN.
- Defined:
  - When wb_wen = 1 and wb_rd = rsN (rsN != 0), rsN_busy is forced to 0 and rsN_byp = wb_data.
  - Decode selects rsN_byp over the register file in that case, saving one stall cycle.
  - Exception: a same-cycle iss_valid to the same rd does not suppress busy for a later reader; it only affects the next cycle.
- Undefined: rsN_byp is tied to 0, and busy is never suppressed.

## Test plan
- Reset: hold rst = 0 two cycles with lsu_valid = 1 and lsu_rd = 5 -> wb_wen = 0, all busy = 0, wb_data = 0 after release.
- EXU write: iss_rd = 3, then exu_valid, exu_sel = 011, exu_rd = 3, exu_snpc = 0x80000008 at cycle N.
  - Expect rs1 = 3 busy until cycle N+1, then wb_wen = 1, wb_rd = 3, wb_data = 0x80000008 in N+1, busy = 0 in N+2.
- Contention: exu_valid and lsu_valid both high, lsu_rd = 7, lsu_mem = 0xdeadbeef.
  - Expect exu_ready = 0, LSU written first, EXU written the following cycle.
- x0 and no-write: exu_rd = 0 with sel 001, then exu_sel = 000 with rd = 4 -> both accepted, wb_wen stays 0, busy[4] unchanged.
- Set/clear collision: writeback to rd 9 in the same cycle as iss_rd = 9 -> busy[9] remains 1.
- Bypass: rs2 = 9 during a wb_wen cycle for rd 9.
  - With YSYX_22041461_WB_BYPASS_EN: rs2_busy = 0 and rs2_byp = wb_data.
  - Without it: rs2_busy = 1 and rs2_byp = 0.
